// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: register offsets, status/data bit positions and default sizing for the RX buffer.
package uart_rx_fifo_pkg;
    localparam int   DEPTH          = 16;
    localparam int   PTR_W          = 4;
    localparam logic UART_RX_DATA   = 1'b0;
    localparam logic UART_RX_STATUS = 1'b1;
    localparam int   ST_VALID       = 0;
    localparam int   ST_FULL        = 1;
    localparam int   ST_OVF         = 2;
    localparam int   ST_COUNT_LSB   = 8;
    localparam int   DATA_VALID     = 8;
endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock circular byte FIFO; a push at full is accepted only alongside a pop.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = r_count == (PTR_W+1)'(DEPTH);
    assign empty  = r_count == '0;
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign dout   = r_mem[r_rd_ptr];
    assign count  = r_count;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffers received UART bytes and exposes them as CPU-readable DATA/STATUS registers
// with a sticky overflow flag and a level interrupt while data is pending.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = uart_rx_fifo_pkg::DEPTH,
    parameter int PTR_W = uart_rx_fifo_pkg::PTR_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_re,
    input  logic [7:0]  rd_data,
    input  logic        cpu_rd,
    input  logic        cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        rx_irq
);
    logic [7:0]     w_dout;
    logic [PTR_W:0] w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_rd_data;
    logic           w_rd_status;
    logic           w_drop;
    logic [31:0]    w_status;
    logic [31:0]    w_data;
    logic           r_ovf;
    logic           r_irq;
    logic [31:0]    r_rdata;

    sync_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (uart_re),
        .pop   (w_rd_data),
        .din   (rd_data),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_rd_data   = cpu_rd && cpu_addr == UART_RX_DATA;
    assign w_rd_status = cpu_rd && cpu_addr == UART_RX_STATUS;
    // A DATA read frees a slot, so a byte arriving at full in the same cycle is kept.
    assign w_drop      = uart_re && w_full && !w_rd_data;
    assign w_status    = (32'(w_count) << ST_COUNT_LSB) | (32'(r_ovf) << ST_OVF)
                       | (32'(w_full) << ST_FULL) | (32'(!w_empty) << ST_VALID);
    assign w_data      = w_empty ? 32'h0 : (32'h1 << DATA_VALID) | 32'(w_dout);
    assign cpu_rdata   = r_rdata;
    assign rx_irq      = r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf   <= 1'b0;
            r_irq   <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_irq <= w_count != '0;
            if (w_drop) r_ovf <= 1'b1;
            else if (w_rd_status) r_ovf <= 1'b0;
            if (cpu_rd) r_rdata <= w_rd_status ? w_status : w_data;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed table plus corner-case sequences for the UART RX FIFO register block.
module tb_uart_rx_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_re = 1'b0;
    logic [7:0]  rd_data = 8'h0;
    logic        cpu_rd = 1'b0;
    logic        cpu_addr = 1'b0;
    logic [31:0] cpu_rdata;
    logic        rx_irq;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic        re;
        logic [7:0]  d;
        logic        rd;
        logic        a;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [10];

    uart_rx_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_re   (uart_re),
        .rd_data   (rd_data),
        .cpu_rd    (cpu_rd),
        .cpu_addr  (cpu_addr),
        .cpu_rdata (cpu_rdata),
        .rx_irq    (rx_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic re, input logic [7:0] d, input logic rd, input logic a);
        uart_re  = re;
        rd_data  = d;
        cpu_rd   = rd;
        cpu_addr = a;
        @(posedge clk);
        #1;
        uart_re = 1'b0;
        cpu_rd  = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0};
        tbl[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 32'h0,     1'b1};
        tbl[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 32'h0,     1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0301,  1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h141,   1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h142,   1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h143,   1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h143,   1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0,     1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0,     1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", cpu_rdata, 32'h0);
        check("reset_irq", 32'(rx_irq), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].re, tbl[i].d, tbl[i].rd, tbl[i].a);
            if (tbl[i].chk_data) check($sformatf("tbl%0d_rdata", i), cpu_rdata, tbl[i].exp_data);
            check($sformatf("tbl%0d_irq", i), 32'(rx_irq), 32'(tbl[i].exp_irq));
        end

        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b0, 8'h0, 1'b1, 1'b1);
        check("full_status", cpu_rdata, 32'h1003);
        check("full_irq", 32'(rx_irq), 32'h1);
        cyc(1'b1, 8'h10, 1'b0, 1'b0);
        cyc(1'b0, 8'h0, 1'b1, 1'b1);
        check("ovf_status", cpu_rdata, 32'h1007);
        cyc(1'b0, 8'h0, 1'b1, 1'b1);
        check("ovf_cleared", cpu_rdata, 32'h1003);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h0, 1'b1, 1'b0);
            check($sformatf("drain%0d", i), cpu_rdata, 32'h100 | 32'(i));
        end
        cyc(1'b0, 8'h0, 1'b1, 1'b0);
        check("drain_empty", cpu_rdata, 32'h0);

        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h99, 1'b1, 1'b0);
        check("full_pushpop_data", cpu_rdata, 32'h120);
        cyc(1'b0, 8'h0, 1'b1, 1'b1);
        check("full_pushpop_status", cpu_rdata, 32'h1003);
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 8'h0, 1'b1, 1'b0);
            check($sformatf("pp_drain%0d", i), cpu_rdata, 32'h120 + 32'(i));
        end
        cyc(1'b0, 8'h0, 1'b1, 1'b0);
        check("pp_last", cpu_rdata, 32'h199);

        cyc(1'b1, 8'h60, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 8'(8'h61 + k), 1'b1, 1'b0);
            check($sformatf("wrap%0d", k), cpu_rdata, 32'h160 + 32'(k));
        end
        cyc(1'b0, 8'h0, 1'b1, 1'b0);
        check("wrap_last", cpu_rdata, 32'h188);
        cyc(1'b0, 8'h0, 1'b1, 1'b1);
        check("wrap_status", cpu_rdata, 32'h0);

        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1);
        check("drop_status_same", cpu_rdata, 32'h1003);
        cyc(1'b0, 8'h0, 1'b1, 1'b1);
        check("drop_status_next", cpu_rdata, 32'h1007);
        cyc(1'b0, 8'h0, 1'b1, 1'b0);
        check("drop_head", cpu_rdata, 32'h170);

        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        cyc(1'b0, 8'h0, 1'b1, 1'b1);
        check("five_status", cpu_rdata, 32'h0501);
        rst_n = 1'b0;
        #2;
        check("async_rst_rdata", cpu_rdata, 32'h0);
        check("async_rst_irq", 32'(rx_irq), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 8'h0, 1'b1, 1'b1);
        check("post_rst_status", cpu_rdata, 32'h0);
        check("post_rst_irq", 32'(rx_irq), 32'h0);
        cyc(1'b1, 8'h0, 1'b1, 1'b0);
        check("post_rst_data", cpu_rdata, 32'h0);
        cyc(1'b0, 8'h0, 1'b1, 1'b0);
        check("post_rst_newbyte", cpu_rdata, 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
